// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide functional unit. It runs one radix-2 step per
// cycle: shift-add multiply on a 2*size-bit accumulator, and restoring divide.
// Operands arrive through a valid/ready handshake. The result is held in DONE
// until the consumer takes it.
//
// Optional build macro:
//   MULDIV_FAST_SPECIAL_EN - when defined, these cases skip the iteration
//                            sequence and finish one cycle after accept:
//                            divide-by-zero, signed overflow, and a multiply
//                            with a zero operand.
//                            Result values are the same in both builds.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     A, B and Sel are valid
//   in_ready     unit can accept (IDLE only)
//   A, B         rs1 / rs2 operands
//   Sel          funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   flush        synchronous abort; overrides in_valid and out_ready
//   busy         operation in CALC or DONE
//   out_valid    S/N/Z valid (DONE only)
//   out_ready    consumer takes the result
//   S            result
//   N, Z         sign / zero flags of S, gated by out_valid
//   state_dbg    current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_valid & in_ready & ~flush. Output side:
// out_valid & out_ready & ~flush. Operands need to be stable only in the
// accept cycle. S changes only when the unit enters DONE.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   input  logic [2:0]      Sel,
   input  logic            flush,
   output logic            busy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] S,
   output logic            N,
   output logic            Z,
   output logic [1:0]      state_dbg
);

   localparam int CW = $clog2(size + 1);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              accept;
   logic              calc_last;

   // Operation context captured at accept
   logic [2:0]        sel_q;
   logic              neg_q;       // product / quotient must be negated
   logic              a_neg_q;     // remainder takes the dividend's sign
   logic              div_zero_q;  // divisor was zero
   logic [size-1:0]   opnd_q;      // multiplicand (mul) or divisor (div) magnitude
   logic [2*size-1:0] acc_q;       // {hi, lo}: product, or {remainder, quotient}
   logic [CW-1:0]     cnt_q;
   logic [size-1:0]   s_q;

   // Accept-time operand decode
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [size-1:0]   a_mag, b_mag;

   // Iteration datapath
   logic [size:0]     mul_sum, rem_sh, div_diff;
   logic [2*size-1:0] acc_step;

   // Finalisation datapath
   logic [2*size-1:0] prod;
   logic [size-1:0]   quot, rmd, result, s_next;

   assign accept = (state_q == ST_IDLE) && in_valid && !flush;

   // --------------------------------------------------------------------------
   // Operand decode: which operands are signed, and their magnitudes
   // --------------------------------------------------------------------------
   always_comb begin
      a_signed = (Sel == F_MULH) || (Sel == F_MULHSU) || (Sel == F_DIV) || (Sel == F_REM);
      b_signed = (Sel == F_MULH) || (Sel == F_DIV) || (Sel == F_REM);
      a_neg    = a_signed && A[size-1];
      b_neg    = b_signed && B[size-1];
      a_mag    = a_neg ? -A : A;
      b_mag    = b_neg ? -B : B;
   end

   // --------------------------------------------------------------------------
   // One radix-2 step.
   // Multiply: add the multiplicand to hi when lo[0] is set, then shift the
   //           whole accumulator right one bit (the carry becomes the new MSB).
   // Divide:   shift {rem, quot} left, trial-subtract the divisor from rem, and
   //           keep the difference only if it did not go negative.
   // --------------------------------------------------------------------------
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*size-1:size]} + {1'b0, opnd_q};
      rem_sh   = {acc_q[2*size-1:size], acc_q[size-1]};
      div_diff = rem_sh - {1'b0, opnd_q};
      acc_step = acc_q;
      if (sel_q[2]) begin
         if (div_diff[size]) begin
            acc_step = {rem_sh[size-1:0], acc_q[size-2:0], 1'b0};
         end else begin
            acc_step = {div_diff[size-1:0], acc_q[size-2:0], 1'b1};
         end
      end else if (acc_q[0]) begin
         acc_step = {mul_sum, acc_q[size-1:1]};
      end else begin
         acc_step = {1'b0, acc_q[2*size-1:1]};
      end
   end

   // --------------------------------------------------------------------------
   // Sign fix-up and result selection.
   // The signed-overflow case (most-negative / -1) needs no special handling:
   // the magnitude quotient 2^(size-1) negates back to itself, and the
   // remainder is 0. Divide-by-zero leaves rem = |A|, which the dividend
   // sign restores to A. Only the quotient is forced to all ones.
   // --------------------------------------------------------------------------
   always_comb begin
      prod   = neg_q ? -acc_q : acc_q;
      quot   = neg_q ? -acc_q[size-1:0] : acc_q[size-1:0];
      rmd    = a_neg_q ? -acc_q[2*size-1:size] : acc_q[2*size-1:size];
      result = '0;
      case (sel_q)
         F_MUL:    result = prod[size-1:0];
         F_MULH:   result = prod[2*size-1:size];
         F_MULHSU: result = prod[2*size-1:size];
         F_MULHU:  result = prod[2*size-1:size];
         F_DIV:    result = div_zero_q ? '1 : quot;
         F_DIVU:   result = div_zero_q ? '1 : quot;
         F_REM:    result = rmd;
         F_REMU:   result = rmd;
         default:  result = '0;
      endcase
   end

`ifdef MULDIV_FAST_SPECIAL_EN
   localparam logic [size-1:0] MOST_NEG = {1'b1, {(size-1){1'b0}}};

   logic            is_special;
   logic [size-1:0] special_res;
   logic            spec_q;
   logic [size-1:0] spec_res_q;

   // Results whose value is known from the operands alone.
   // Sel[1] selects a remainder op, and Sel[0] selects an unsigned op.
   always_comb begin
      is_special  = 1'b0;
      special_res = '0;
      if (Sel[2]) begin
         if (B == '0) begin
            is_special  = 1'b1;
            special_res = Sel[1] ? A : '1;
         end else if (!Sel[0] && (A == MOST_NEG) && (B == '1)) begin
            is_special  = 1'b1;
            special_res = Sel[1] ? '0 : A;
         end
      end else if ((A == '0) || (B == '0)) begin
         is_special  = 1'b1;
         special_res = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spec_q     <= 1'b0;
         spec_res_q <= '0;
      end else if (accept) begin
         spec_q     <= is_special;
         spec_res_q <= special_res;
      end
   end

   assign calc_last = (cnt_q == '0) || spec_q;
   assign s_next    = spec_q ? spec_res_q : result;
`else
   assign calc_last = (cnt_q == '0);
   assign s_next    = result;
`endif

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (accept) state_d = ST_CALC;
         end
         ST_CALC: begin
            busy = 1'b1;
            if (calc_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   // --------------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= '0;
         neg_q      <= 1'b0;
         a_neg_q    <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         s_q        <= '0;
      end else if (accept) begin
         sel_q      <= Sel;
         neg_q      <= a_neg ^ b_neg;
         a_neg_q    <= a_neg;
         div_zero_q <= (B == '0);
         opnd_q     <= Sel[2] ? b_mag : a_mag;
         acc_q      <= {{size{1'b0}}, (Sel[2] ? a_mag : b_mag)};
         cnt_q      <= CW'(size);
      end else if ((state_q == ST_CALC) && !flush) begin
         if (calc_last) begin
            s_q <= s_next;
         end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign S         = s_q;
   assign N         = out_valid && s_q[size-1];
   assign Z         = out_valid && (s_q == '0);
   assign state_dbg = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle functional unit executing the RV32M multiply/divide group on `size`-bit operands, alongside the single-cycle ALU/shifter functional unit in the EX stage. Operands are accepted through a valid/ready handshake; the pipeline stalls on `busy` until the result is delivered. The result path carries N and Z flags in the same convention as the combinational unit; C and V are not produced.

## Interface
- `size`, 32, operand/result width; must be even and ≥ 4.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands and `Sel` valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `A`  in  `size`  rs1 operand (dividend / multiplicand).
- `B`  in  `size`  rs2 operand (divisor / multiplier).
- `Sel`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `flush`  in  1  synchronous abort of any operation in flight.
- `busy`  out  1  high in CALC or DONE.
- `out_valid`  out  1  `S`, `N`, `Z` valid; high only in DONE.
- `out_ready`  in  1  consumer takes result.
- `S`  out  `size`  result.
- `N`  out  1  `S[size-1]`, gated by `out_valid`.
- `Z`  out  1  `S == 0`, gated by `out_valid`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `in_valid & ~flush`, latch operand magnitudes, sign flags, and `Sel`; load iteration counter with `size`; go to CALC.
- CALC: one radix-2 step per cycle (shift-add multiply on a 2·`size`-bit accumulator; restoring divide). When the counter reaches 0, apply sign fix-up (two's-complement negate of product, quotient, or remainder as required), register `S`, and go to DONE.
- DONE: hold `S` stable; on `out_ready`, go to IDLE. No operation is accepted in the same cycle.
- `flush` in any state: go to IDLE next edge; the result is discarded. `flush` overrides `in_valid` and `out_ready`.
- Signedness: MUL and MULHU use unsigned magnitudes; MULH uses signed × signed; MULHSU uses signed A × unsigned B. MUL returns the low `size` bits, and the MULH variants return the high `size` bits of the 2·`size`-bit product.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = A (REM and REMU).
- Signed overflow (A = most-negative, B = −1, DIV/REM): quotient = A, remainder = 0.
- Remainder takes the sign of the dividend.

## Timing
- Reset: state IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `S`=0, `N`=0, `Z`=0, counter 0.
- Accept at edge T. `out_valid` rises after edge T+`size`+1, giving a latency of `size`+1 cycles (33 for `size`=32).
- `S` changes only on entry to DONE.
- Minimum issue interval: `size`+3 cycles with `out_ready` held high.
- Operands must be stable only in the accept cycle.
- An `rst_n` assertion mid-operation clears the state immediately (asynchronously); no partial result is visible.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined: divide-by-zero, signed overflow, and operand 0 on any multiply bypass CALC. The registered result enters DONE at edge T+1, and `out_valid` is high from cycle T+1.
- Undefined: special cases run the full `size`-iteration sequence with identical latency to normal operations. Result values are identical in both builds.

## Test plan
- Reset mid-CALC, then MUL A=7, B=−3 → S=0xFFFFFFEB, N=1, Z=0, `out_valid` exactly 33 cycles after accept.
- MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV/REM A=−7, B=2 → −3 and −1; DIVU with B=0 → 0xFFFFFFFF; REMU A=5, B=0 → 5.
- DIV A=0x80000000, B=−1 → 0x80000000; REM → 0, Z=1. With `MULDIV_FAST_SPECIAL_EN`, `out_valid` one cycle after accept.
- Hold `out_ready`=0 for 10 cycles in DONE → S stable, `in_ready`=0; `in_valid` ignored until release.
- `flush` at CALC cycle 5 with `in_valid` also high → IDLE next edge, no `out_valid`, no new accept that cycle.
